// File: rtl/tg_cmd_pkg.sv
// tg_cmd_pkg: shared types and constants for the traffic-generator command sequencer
package tg_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_GEN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic PASS_WRITE = 1'b0;
    localparam logic PASS_READ  = 1'b1;

    // Burst length is the PRBS low nibble plus one, giving 1..16 beats
    localparam int BLEN_OFFSET = 1;

    function automatic logic [4:0] blen_map(input logic [3:0] nib);
        return {1'b0, nib} + 5'(BLEN_OFFSET);
    endfunction

endpackage

// File: rtl/tg_cmd_fifo.sv
// tg_cmd_fifo: small synchronous FIFO with full/empty flags, head entry presented from registers
module tg_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr;
    logic             rd;

    assign full_o  = count == CW'(DEPTH);
    assign empty_o = count == '0;
    assign wr      = push_i & ~full_o;
    assign rd      = pop_i & ~empty_o;
    assign rdata_o = mem[rd_ptr];

    // Storage, pointers and occupancy; a push into a full FIFO is dropped even if a pop coincides
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) mem[wr_ptr] <= wdata_i;
            wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= rd ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(wr) - CW'(rd);
        end
    end

endmodule

// File: rtl/tg_cmd_sequencer.sv
// tg_cmd_sequencer: builds write-then-replayed-read command passes from the PRBS generators
module tg_cmd_sequencer
    import tg_cmd_pkg::*;
#(
    parameter int              ADDR_WIDTH = 32,
    parameter int              SEED_WIDTH = 32,
    parameter int              BLEN_WIDTH = 5,
    parameter int              ALIGN_BITS = 6,
    parameter logic [31:0]     ADDR_SEED  = 32'h0000_2000,
    parameter logic [31:0]     BLEN_SEED  = 32'h0000_1A2B,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [15:0]           num_cmds_i,
    input  logic [SEED_WIDTH-1:0] addr_prbs_i,
    input  logic [SEED_WIDTH-1:0] blen_prbs_i,
    output logic                  prbs_seed_init_o,
    output logic                  prbs_clk_en_o,
    output logic [SEED_WIDTH-1:0] addr_seed_o,
    output logic [SEED_WIDTH-1:0] blen_seed_o,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [ADDR_WIDTH-1:0] cmd_addr_o,
    output logic [BLEN_WIDTH-1:0] cmd_blen_o,
    output logic                  cmd_rnw_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CMD_W = ADDR_WIDTH + BLEN_WIDTH + 1;

    state_t                state, state_nx;
    logic                  rnw, rnw_nx;
    logic                  mode_q, mode_nx;
    logic [15:0]           num_q, num_nx;
    logic [15:0]           gen_cnt, gen_cnt_nx;
    logic [ADDR_WIDTH-1:0] base, base_nx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BLEN_WIDTH-1:0] blen;
    logic                  push;
    logic                  full;
    logic                  empty;
    logic [CMD_W-1:0]      rdata;
    logic                  unused_prbs;

    assign addr_seed_o   = SEED_WIDTH'(ADDR_SEED);
    assign blen_seed_o   = SEED_WIDTH'(BLEN_SEED);
    assign blen          = BLEN_WIDTH'(blen_map(blen_prbs_i[3:0]));
    assign addr          = mode_q ? {addr_prbs_i[ADDR_WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}} : base;
    assign prbs_clk_en_o = push;
    assign busy_o        = state != ST_IDLE;
    assign cmd_valid_o   = ~empty;
    assign {cmd_addr_o, cmd_blen_o, cmd_rnw_o} = rdata;
    assign unused_prbs   = ^{addr_prbs_i, blen_prbs_i};

    tg_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .wdata_i ({addr, blen, rnw}),
        .pop_i   (cmd_ready_i),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty)
    );

    // Control state, pass flag, latched run parameters and generation progress
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ST_IDLE;
            rnw     <= PASS_WRITE;
            mode_q  <= 1'b0;
            num_q   <= '0;
            gen_cnt <= '0;
            base    <= '0;
        end else begin
            state   <= state_nx;
            rnw     <= rnw_nx;
            mode_q  <= mode_nx;
            num_q   <= num_nx;
            gen_cnt <= gen_cnt_nx;
            base    <= base_nx;
        end
    end

    // Sequencing: seed, generate one command per free FIFO slot, drain, then replay as reads
    always_comb begin
        state_nx         = state;
        rnw_nx           = rnw;
        mode_nx          = mode_q;
        num_nx           = num_q;
        gen_cnt_nx       = gen_cnt;
        base_nx          = base;
        push             = 1'b0;
        prbs_seed_init_o = 1'b0;
        done_o           = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    mode_nx  = mode_i;
                    num_nx   = num_cmds_i;
                    rnw_nx   = PASS_WRITE;
                    state_nx = (num_cmds_i == '0) ? ST_DONE : ST_SEED;
                end
            end
            ST_SEED: begin
                prbs_seed_init_o = 1'b1;
                gen_cnt_nx       = '0;
                base_nx          = '0;
                state_nx         = ST_GEN;
            end
            ST_GEN: begin
                if (gen_cnt == num_q) begin
                    state_nx = ST_DRAIN;
                end else if (!full) begin
                    push       = 1'b1;
                    gen_cnt_nx = gen_cnt + 16'd1;
                    base_nx    = base + (ADDR_WIDTH'(blen) << ALIGN_BITS);
                end
            end
            ST_DRAIN: begin
                if (empty) begin
                    rnw_nx   = PASS_READ;
                    state_nx = (rnw == PASS_READ) ? ST_DONE : ST_SEED;
                end
            end
            ST_DONE: begin
                done_o   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
